// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - sequential unsigned restoring divider, one quotient bit per cycle
module seq_divider #(
  parameter int size = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [size-1:0] dividend,
  input  logic [size-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [size-1:0] quotient,
  output logic [size-1:0] remainder,
  output logic            div_by_zero
);

  localparam int cw = $clog2(size);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nx;
  logic [cw-1:0]   cnt;
  logic [size-1:0] dvd;
  logic [size-1:0] dvs;
  logic [size-1:0] r;

  logic [size:0]   t;
  logic            borrow;
  logic [size-1:0] diff;
  logic [size-1:0] r_nx;
  logic [size-1:0] dvd_nx;
  logic            accept;
  logic            last;

  // Partial remainder stays below the divisor, so it fits in size bits; the
  // dividend register shifts out dividend bits and shifts in quotient bits.
  always_comb begin
    t      = {r, dvd[size-1]};
    borrow = t < {1'b0, dvs};
    diff   = t[size-1:0] - dvs;
    r_nx   = borrow ? t[size-1:0] : diff;
    dvd_nx = {dvd[size-2:0], ~borrow};
    accept = start && (state == IDLE || state == DONE);
    last   = (cnt == cw'(size - 1));
  end

  always_comb begin
    state_nx = state;
    if (accept) begin
      state_nx = (divisor == '0) ? DONE : RUN;
    end else begin
      case (state)
        IDLE:    state_nx = IDLE;
        RUN:     state_nx = last ? DONE : RUN;
        DONE:    state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      dvd         <= '0;
      dvs         <= '0;
      r           <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        if (divisor != '0) begin
          dvd         <= dividend;
          dvs         <= divisor;
          r           <= '0;
          cnt         <= '0;
          div_by_zero <= 1'b0;
        end else begin
          quotient    <= '1;
          remainder   <= dividend;
          div_by_zero <= 1'b1;
        end
      end else if (state == RUN) begin
        r   <= r_nx;
        dvd <= dvd_nx;
        cnt <= cnt + cw'(1);
        if (last) begin
          quotient  <= dvd_nx;
          remainder <= r_nx;
        end
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: doc/seq_divider.md
# seq_divider

Sequential unsigned restoring divider for the arithmetic library. It is the inverse operation to the library's adder blocks: each cycle it performs one trial subtraction (a borrow-propagating subtract of width `size+1`). It accepts a dividend/divisor pair on a `start` pulse and produces one quotient bit per cycle, MSB first. It then holds quotient and remainder stable until the next accepted request.

## Interface
- `size`, default 4: operand, quotient and remainder width in bits; legal values are 2 to 32.

- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `start`  input  1  request strobe; sampled on the rising edge of `clk`.
- `dividend`  input  size  unsigned dividend; sampled only on the accepting edge.
- `divisor`  input  size  unsigned divisor; sampled only on the accepting edge.
- `busy`  output  1  high while state is RUN.
- `done`  output  1  single-cycle pulse; high while state is DONE.
- `quotient`  output  size  result quotient; held until the next accept.
- `remainder`  output  size  result remainder; held until the next accept.
- `div_by_zero`  output  1  high with the result of a request whose divisor was 0; held until the next accept.

## Operation
- States:
  - IDLE: reset state.
  - RUN: iterating.
  - DONE: one cycle, result presented.
- Accept condition: `start`=1 on an edge with state IDLE or DONE. `start` during RUN is ignored; no queueing, no error flag.
- On accept with `divisor`≠0:
  - Latch both operands.
  - Clear the partial remainder R (width `size+1`) and the quotient shift register.
  - Clear the iteration counter.
  - Clear `div_by_zero`.
  - Go to RUN.
- On accept with `divisor`=0:
  - Go directly to DONE.
  - Set `quotient` to all ones and `remainder` to `dividend`.
  - Set `div_by_zero`=1.
- RUN iteration, counter k = 0 … size-1:
  - Form T = {R[size-1:0], next dividend bit, MSB first}.
  - Compute D = T − {1'b0, divisor} at width `size+1`.
  - If the borrow is 0, R ← D and shift 1 into the quotient.
  - Otherwise R ← T (restore) and shift 0 into the quotient.
- After iteration k = size-1, go to DONE.
  - `quotient` and `remainder` (= R[size-1:0]) update on that same edge.
- DONE → IDLE on the next edge, unless a new accept occurs, in which case go to RUN (or DONE for a zero divisor).
- Arithmetic rules:
  - All values are unsigned.
  - R never exceeds `divisor`−1 after an iteration.
  - `dividend` = `quotient`·`divisor` + `remainder` holds whenever `div_by_zero`=0.
- Intermediate quotient and remainder state is internal. The `quotient` and `remainder` outputs change only on the DONE-entry edge or on reset.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `quotient`=0, `remainder`=0, `div_by_zero`=0, counter=0.
- Reset has priority over `start` and over every state. Asserting `rst` mid-RUN aborts the operation; no `done` is produced.
- Let E0 be the accepting edge.
  - Normal request: `busy`=1 from E0 through edge E`size`. `done`=1 for exactly the one cycle following edge E`size`. Total latency is `size` cycles from accept to `done`.
  - Zero divisor: `done`=1 in the cycle following E0, and `busy` stays 0. Latency is 1 cycle.
- Throughput: a new request may be accepted on the edge that ends the DONE cycle. Back-to-back issue gives one result every `size`+1 cycles.
- Operand inputs may change freely after the accepting edge.
- `done` and `busy` are never high simultaneously.

## Test plan
- `size`=4, `dividend`=13, `divisor`=3, `start` for 1 cycle → `busy` for 4 cycles, then `done` pulse with `quotient`=4, `remainder`=1, `div_by_zero`=0; outputs held afterwards.
- Boundary operands, one request at a time:
  - 15/1 → `quotient`=15, `remainder`=0.
  - 5/7 → `quotient`=0, `remainder`=5.
  - 15/15 → `quotient`=1, `remainder`=0.
  - 0/9 → `quotient`=0, `remainder`=0.
  - Each completes with latency 4.
- 9/0 → `done` one cycle after accept, `busy` never high, `quotient`=15, `remainder`=9, `div_by_zero`=1. The next accepted 8/2 clears `div_by_zero` and gives `quotient`=4, `remainder`=0.
- Start 13/3, then assert `start` with 2/1 on the 2nd RUN cycle → second request ignored; result is 4 r 1; exactly one `done`.
- Start 14/4, assert `rst` on the 2nd RUN cycle → next cycle all outputs 0, state IDLE, no `done`. A subsequent 7/2 returns 3 r 1.
- Start 13/3, then assert `start` with 11/2 during the DONE cycle → 4 r 1 is presented, then 5 r 1 after 4 more cycles.
- Exhaustive sweep of all 256 operand pairs at `size`=4 → quotient, remainder and `div_by_zero` match a reference model.
